dcr_bank: RTL and testbench
===========================

Name: dcr_bank

Overview:
Parametrised successor to the single-register device control register. Holds a small addressed bank of device control registers: thread count, kernel arguments, a control/launch register and a read-only status register. It also runs a kernel-launch state machine (IDLE/RUNNING/DONE) that drives the dispatcher's start line and locks configuration while a kernel is running. It sits between the host-facing control interface and the dispatcher/cores.

Parameters:
DATA_BITS, 8, width of every register and of the write/read data buses.
ADDR_BITS, 3, register address width.
NUM_REGS, 6, implemented addresses 0..NUM_REGS-1; must be >=3 and <=2**ADDR_BITS.
THREAD_COUNT_RESET, 0, reset value of THREAD_COUNT.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
device_control_write_enable  input  1  write strobe, one write per asserted cycle.
device_control_write_addr  input  ADDR_BITS  write register address.
device_control_data  input  DATA_BITS  write data.
device_control_read_addr  input  ADDR_BITS  read register address.
device_control_read_data  output  DATA_BITS  registered read data.
thread_count  output  DATA_BITS  current THREAD_COUNT register.
kernel_args  output  (NUM_REGS-3)*DATA_BITS  ARG registers, address 3 in the LSBs.
start  output  1  high for the whole RUNNING state.
done  input  1  dispatcher kernel-complete pulse/level.
busy  output  1  high in RUNNING.
kernel_done  output  1  high in DONE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Register map:
  - Addr 0: THREAD_COUNT, R/W.
  - Addr 1: CTRL, write-only, reads 0. bit0 = launch, bit1 = clear_done; the remaining bits are ignored.
  - Addr 2: STATUS, read-only. bit0 = busy, bit1 = kernel_done, bit2 = err (sticky), bit3 = aborted (see optional feature); upper bits 0.
  - Addr 3..NUM_REGS-1: ARG registers, R/W.
  - Addresses >= NUM_REGS: writes dropped silently; reads return 0.
- Reset values: THREAD_COUNT = THREAD_COUNT_RESET; ARGs = 0; state = IDLE; err = 0; device_control_read_data = 0; start/busy/kernel_done = 0.
- Reads: device_control_read_data is updated every cycle from device_control_read_addr, so it has 1-cycle latency.
  - Reading an address written in the same cycle returns the old value.
  - STATUS reads reflect the state before the current edge.
- State machine (transitions are evaluated against the current state):
  - IDLE or DONE, write CTRL with launch=1:
    - If THREAD_COUNT != 0: go to RUNNING.
    - If THREAD_COUNT == 0: stay in the current state and set err.
  - DONE, write CTRL with clear_done=1 and launch=0: go to IDLE.
  - DONE, launch=1 and clear_done=1 together: launch wins, go to RUNNING.
  - RUNNING, done=1: go to DONE. done is ignored in IDLE and DONE.
  - RUNNING, any write to THREAD_COUNT or an ARG register: write dropped and err set. A CTRL write while RUNNING is ignored and does not set err.
- Simultaneous events in RUNNING: done=1 together with a THREAD_COUNT/ARG write gives DONE next cycle, and the write is still dropped with err set.
- Outputs: start and busy = (state == RUNNING); kernel_done = (state == DONE). All three are derived directly from the state register, with no extra latency.
- err clears only on reset, or on a write to STATUS with bit2=1 (write-1-to-clear; the other STATUS bits are unaffected).
- Reset mid-RUNNING: the next cycle is IDLE with start=0. No done is required from the dispatcher.

Optional Feature:
DCR_ABORT_EN.
- Defined:
  - CTRL bit2 = abort. Abort in RUNNING goes to IDLE the next cycle (start drops) and sets the aborted flag (STATUS bit3).
  - The aborted flag clears on the next successful launch or on reset.
  - Abort and done in the same cycle: done wins (go to DONE, aborted stays 0).
  - Abort outside RUNNING is ignored.
- Undefined: CTRL bit2 is ignored, STATUS bit3 reads 0, and no abort logic is present.

Test Plan:
- Reset, then read addr 0, 2, 3 -> read_data 0x00 at each, one cycle after the address is presented; start=0, busy=0.
- Write THREAD_COUNT=0x10, ARG(3)=0xA5, then CTRL=0x01 -> thread_count=0x10, start=1 the cycle after the CTRL write, STATUS read=0x01.
- While RUNNING, write THREAD_COUNT=0x20 -> thread_count stays 0x10, STATUS=0x05; then pulse done -> kernel_done=1, start=0, STATUS=0x06; write STATUS=0x04 -> STATUS=0x02.
- THREAD_COUNT=0, write CTRL=0x01 -> stays IDLE, start=0, STATUS=0x04; write to addr 7 (NUM_REGS=6) then read addr 7 -> 0x00.
- In DONE, write CTRL=0x03 -> RUNNING next cycle (launch wins); in RUNNING, a done pulse together with an ARG write -> DONE, ARG unchanged, err=1.
- DCR_ABORT_EN defined: launch, then CTRL=0x04 -> IDLE, start=0, STATUS=0x08; relaunch -> STATUS=0x01.

Source files
------------

// File: rtl/dcr_bank.sv
// Device control register bank with kernel-launch FSM.
// Optional abort support is enabled by defining DCR_ABORT_EN.
module dcr_bank #(
    parameter int DATA_BITS          = 8,
    parameter int ADDR_BITS          = 3,
    parameter int NUM_REGS           = 6,
    parameter int THREAD_COUNT_RESET = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              device_control_write_enable,
    input  logic [ADDR_BITS-1:0]              device_control_write_addr,
    input  logic [DATA_BITS-1:0]              device_control_data,
    input  logic [ADDR_BITS-1:0]              device_control_read_addr,
    output logic [DATA_BITS-1:0]              device_control_read_data,
    output logic [DATA_BITS-1:0]              thread_count,
    output logic [(NUM_REGS-3)*DATA_BITS-1:0] kernel_args,
    output logic                              start,
    input  logic                              done,
    output logic                              busy,
    output logic                              kernel_done
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] RUNNING = 2'b01;
    localparam logic [1:0] DONE    = 2'b10;

    localparam logic [ADDR_BITS-1:0] A_TC     = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] A_CTRL   = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] A_STATUS = ADDR_BITS'(2);

    logic [1:0]                           state;
    logic [1:0]                           state_nxt;
    logic [NUM_REGS-4:0][DATA_BITS-1:0]   args;
    logic                                 err;
    logic                                 aborted;
    logic [DATA_BITS-1:0]                 status;
    logic [DATA_BITS-1:0]                 rd_nxt;

    logic wr_tc;
    logic wr_ctrl;
    logic wr_status;
    logic wr_arg;
    logic launch;
    logic clear_done;
    logic abort_req;
    logic launch_ok;
    logic launch_bad;
    logic cfg_block;
    logic do_abort;

    assign wr_tc     = device_control_write_enable &&
                       (device_control_write_addr == A_TC);
    assign wr_ctrl   = device_control_write_enable &&
                       (device_control_write_addr == A_CTRL);
    assign wr_status = device_control_write_enable &&
                       (device_control_write_addr == A_STATUS);

    // Any write landing in the ARG window.
    always_comb begin
        wr_arg = 1'b0;
        for (int i = 0; i < NUM_REGS - 3; i++) begin
            if (device_control_write_enable &&
                device_control_write_addr == ADDR_BITS'(i + 3))
                wr_arg = 1'b1;
        end
    end

    assign launch     = wr_ctrl && device_control_data[0];
    assign clear_done = wr_ctrl && device_control_data[1];

`ifdef DCR_ABORT_EN
    assign abort_req = wr_ctrl && device_control_data[2];
`else
    assign abort_req = 1'b0;
`endif

    assign launch_ok  = launch && (state != RUNNING) && (thread_count != '0);
    assign launch_bad = launch && (state != RUNNING) && (thread_count == '0);
    assign cfg_block  = (state == RUNNING) && (wr_tc || wr_arg);
    assign do_abort   = abort_req && (state == RUNNING) && !done;

    // Next-state logic; launch takes priority over clear_done in DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (launch_ok)
                    state_nxt = RUNNING;
            end
            RUNNING: begin
                if (done)
                    state_nxt = DONE;
                else if (do_abort)
                    state_nxt = IDLE;
            end
            DONE: begin
                if (launch_ok)
                    state_nxt = RUNNING;
                else if (clear_done && !launch)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Configuration registers, locked while a kernel runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            thread_count <= DATA_BITS'(THREAD_COUNT_RESET);
            args         <= '0;
        end else if (state != RUNNING) begin
            if (wr_tc)
                thread_count <= device_control_data;
            for (int i = 0; i < NUM_REGS - 3; i++) begin
                if (device_control_write_enable &&
                    device_control_write_addr == ADDR_BITS'(i + 3))
                    args[i] <= device_control_data;
            end
        end
    end

    // Sticky error: set by blocked config writes or zero-thread launch.
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (cfg_block || launch_bad)
            err <= 1'b1;
        else if (wr_status && device_control_data[2])
            err <= 1'b0;
    end

`ifdef DCR_ABORT_EN
    // Aborted flag: set on abort, cleared by the next good launch.
    always_ff @(posedge clk) begin
        if (reset)
            aborted <= 1'b0;
        else if (do_abort)
            aborted <= 1'b1;
        else if (launch_ok)
            aborted <= 1'b0;
    end
`else
    assign aborted = 1'b0;
`endif

    assign start       = (state == RUNNING);
    assign busy        = (state == RUNNING);
    assign kernel_done = (state == DONE);
    assign kernel_args = args;

    // STATUS view of the current state.
    always_comb begin
        status    = '0;
        status[0] = busy;
        status[1] = kernel_done;
        status[2] = err;
        status[3] = aborted;
    end

    // Read mux; unmapped and write-only addresses return zero.
    always_comb begin
        rd_nxt = '0;
        if (device_control_read_addr == A_TC)
            rd_nxt = thread_count;
        else if (device_control_read_addr == A_STATUS)
            rd_nxt = status;
        for (int i = 0; i < NUM_REGS - 3; i++) begin
            if (device_control_read_addr == ADDR_BITS'(i + 3))
                rd_nxt = args[i];
        end
    end

    // Registered read data, one cycle of latency.
    always_ff @(posedge clk) begin
        if (reset)
            device_control_read_data <= '0;
        else
            device_control_read_data <= rd_nxt;
    end

endmodule

// File: tb/tb_dcr_bank.sv
// Directed self-checking bench for dcr_bank.
// Abort scenario runs only when DCR_ABORT_EN is defined.
module tb_dcr_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic [2:0]  raddr;
    logic [7:0]  rdata;
    logic [7:0]  tc;
    logic [23:0] kargs;
    logic        start;
    logic        done;
    logic        busy;
    logic        kdone;

    int total = 0;
    int bad = 0;

    dcr_bank #(
        .DATA_BITS(8),
        .ADDR_BITS(3),
        .NUM_REGS(6),
        .THREAD_COUNT_RESET(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .device_control_write_enable(we),
        .device_control_write_addr(waddr),
        .device_control_data(wdata),
        .device_control_read_addr(raddr),
        .device_control_read_data(rdata),
        .thread_count(tc),
        .kernel_args(kargs),
        .start(start),
        .done(done),
        .busy(busy),
        .kernel_done(kdone)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        raddr = a;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr = '0; done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        total++; if ({start, busy, kdone} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {start, busy, kdone}); end
        total++; if (tc !== 8'h00) begin bad++; $display("FAIL reset_tc got=%h exp=00", tc); end
        rd(3'd0);
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rd0 got=%h exp=00", rdata); end
        rd(3'd2);
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rd2 got=%h exp=00", rdata); end
        rd(3'd3);
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rd3 got=%h exp=00", rdata); end
    endtask

    task automatic test_launch();
        wr(3'd0, 8'h10);
        wr(3'd3, 8'hA5);
        total++; if (kargs !== 24'h0000A5) begin bad++; $display("FAIL launch_args got=%h exp=0000a5", kargs); end
        total++; if (start !== 1'b0) begin bad++; $display("FAIL launch_pre_start got=%b exp=0", start); end
        wr(3'd1, 8'h01);
        total++; if (tc !== 8'h10) begin bad++; $display("FAIL launch_tc got=%h exp=10", tc); end
        total++; if ({start, busy, kdone} !== 3'b110) begin bad++; $display("FAIL launch_flags got=%b exp=110", {start, busy, kdone}); end
        rd(3'd2);
        total++; if (rdata !== 8'h01) begin bad++; $display("FAIL launch_status got=%h exp=01", rdata); end
    endtask

    task automatic test_running_lock();
        wr(3'd0, 8'h20);
        total++; if (tc !== 8'h10) begin bad++; $display("FAIL lock_tc got=%h exp=10", tc); end
        rd(3'd2);
        total++; if (rdata !== 8'h05) begin bad++; $display("FAIL lock_status got=%h exp=05", rdata); end
        wr(3'd1, 8'h02);
        total++; if (start !== 1'b1) begin bad++; $display("FAIL lock_ctrl_ignored got=%b exp=1", start); end
        done = 1'b1; tick(); done = 1'b0;
        total++; if ({start, busy, kdone} !== 3'b001) begin bad++; $display("FAIL done_flags got=%b exp=001", {start, busy, kdone}); end
        rd(3'd2);
        total++; if (rdata !== 8'h06) begin bad++; $display("FAIL done_status got=%h exp=06", rdata); end
        wr(3'd2, 8'h04);
        rd(3'd2);
        total++; if (rdata !== 8'h02) begin bad++; $display("FAIL w1c_status got=%h exp=02", rdata); end
    endtask

    task automatic test_zero_launch();
        wr(3'd1, 8'h02);
        total++; if (kdone !== 1'b0) begin bad++; $display("FAIL clear_done got=%b exp=0", kdone); end
        done = 1'b1; tick(); done = 1'b0;
        total++; if (kdone !== 1'b0) begin bad++; $display("FAIL idle_done_ignored got=%b exp=0", kdone); end
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h01);
        total++; if (start !== 1'b0) begin bad++; $display("FAIL zero_launch_start got=%b exp=0", start); end
        rd(3'd2);
        total++; if (rdata !== 8'h04) begin bad++; $display("FAIL zero_launch_status got=%h exp=04", rdata); end
        wr(3'd7, 8'h55);
        rd(3'd7);
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL unmapped_rd got=%h exp=00", rdata); end
        total++; if (kargs !== 24'h0000A5) begin bad++; $display("FAIL unmapped_wr got=%h exp=0000a5", kargs); end
        rd(3'd1);
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL ctrl_rd got=%h exp=00", rdata); end
        wr(3'd2, 8'h04);
    endtask

    task automatic test_back_to_back();
        wr(3'd0, 8'h03);
        wr(3'd1, 8'h01);
        done = 1'b1; tick(); done = 1'b0;
        total++; if (kdone !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", kdone); end
        raddr = 3'd3; we = 1'b1; waddr = 3'd3; wdata = 8'h5A;
        tick();
        we = 1'b0;
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL rd_old_value got=%h exp=a5", rdata); end
        tick();
        total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL rd_new_value got=%h exp=5a", rdata); end
        wr(3'd1, 8'h03);
        total++; if ({start, kdone} !== 2'b10) begin bad++; $display("FAIL launch_wins got=%b exp=10", {start, kdone}); end
        done = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 8'h77;
        tick();
        done = 1'b0; we = 1'b0;
        total++; if (kdone !== 1'b1) begin bad++; $display("FAIL done_with_wr got=%b exp=1", kdone); end
        total++; if (kargs !== 24'h00005A) begin bad++; $display("FAIL arg_dropped got=%h exp=00005a", kargs); end
        rd(3'd2);
        total++; if (rdata !== 8'h06) begin bad++; $display("FAIL done_wr_status got=%h exp=06", rdata); end
    endtask

    task automatic test_reset_mid_run();
        wr(3'd2, 8'h04);
        wr(3'd1, 8'h01);
        total++; if (start !== 1'b1) begin bad++; $display("FAIL mid_run_start got=%b exp=1", start); end
        reset = 1'b1; tick(); reset = 1'b0;
        total++; if ({start, busy, kdone} !== 3'b000) begin bad++; $display("FAIL mid_run_reset got=%b exp=000", {start, busy, kdone}); end
        total++; if (tc !== 8'h00 || kargs !== 24'h0) begin bad++; $display("FAIL mid_run_regs tc=%h args=%h exp=00/0", tc, kargs); end
    endtask

`ifdef DCR_ABORT_EN
    task automatic test_abort();
        wr(3'd0, 8'h08);
        wr(3'd1, 8'h01);
        wr(3'd1, 8'h04);
        total++; if (start !== 1'b0) begin bad++; $display("FAIL abort_start got=%b exp=0", start); end
        rd(3'd2);
        total++; if (rdata !== 8'h08) begin bad++; $display("FAIL abort_status got=%h exp=08", rdata); end
        wr(3'd1, 8'h01);
        rd(3'd2);
        total++; if (rdata !== 8'h01) begin bad++; $display("FAIL relaunch_status got=%h exp=01", rdata); end
        we = 1'b1; waddr = 3'd1; wdata = 8'h04; done = 1'b1;
        tick();
        we = 1'b0; done = 1'b0;
        rd(3'd2);
        total++; if (rdata !== 8'h02) begin bad++; $display("FAIL abort_vs_done got=%h exp=02", rdata); end
    endtask
`endif

    initial begin
        test_reset();
        test_launch();
        test_running_lock();
        test_zero_launch();
        test_back_to_back();
        test_reset_mid_run();
`ifdef DCR_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
